// File: rtl/ncl_dualrail_sync_rx.sv
// ncl_dualrail_sync_rx: clocked receiver for an NCL dual-rail word source.
// Synchronises every rail, waits for a stable DATA or NULL wavefront,
// drives the NCL acknowledge (ki) and hands each DATA word to a
// valid/ready consumer. An optional checker flags words that do not form
// an incrementing count with matching carry-out.
module ncl_dualrail_sync_rx #(
  parameter int W         = 32,
  parameter int STABLE    = 2,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic         clk,
  input  logic         init,
  input  logic [W-1:0] d_rail1,
  input  logic [W-1:0] d_rail0,
  input  logic         c_rail1,
  input  logic         c_rail0,
  output logic         ki,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_carry,
  output logic [31:0]  word_count,
  output logic         err_illegal,
  output logic         seq_err
);

  localparam int CW = $clog2(STABLE + 1) + 1;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [W-1:0]  INC_C    = W'(1);

  typedef enum logic [0:0] {
    S_WAIT_NULL = 1'b0,
    S_WAIT_DATA = 1'b1
  } state_t;

  // Every pair is exactly one-hot: a complete DATA wavefront.
  function automatic logic pairs_complete(input logic [W:0] r1, input logic [W:0] r0);
    return &(r1 ^ r0);
  endfunction

  // No rail asserted: a NULL wavefront.
  function automatic logic pairs_null(input logic [W:0] r1, input logic [W:0] r0);
    return ~|(r1 | r0);
  endfunction

  // Any pair with both rails high can never be a legal code.
  function automatic logic pairs_illegal(input logic [W:0] r1, input logic [W:0] r0);
    return |(r1 & r0);
  endfunction

  // Bit W of each rail vector carries the carry-out pair.
  logic [W:0]    r_sync1_r1, r_sync1_r0;
  logic [W:0]    r_s_r1, r_s_r0;
  logic [W:0]    r_prev_r1, r_prev_r0;
  logic [1:0]    r_fill;
  logic [CW-1:0] r_run;
  state_t        r_state;
  logic          r_ki;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_carry;
  logic [31:0]   r_word_count;
  logic          r_err_illegal;
  logic          r_seq_err;
  logic [W-1:0]  r_seq_prev;
  logic          r_have_prev;

  logic          w_valid_s;
  logic          w_same;
  logic [CW-1:0] w_run;
  logic          w_stable;
  logic          w_acc_null;
  logic          w_acc_data;
  logic          w_illegal;
  logic          w_seq_bad;
  state_t        w_state_next;
  logic          w_capture;

  assign w_valid_s = r_fill[1];

  // Two-flop synchroniser on every rail; r_fill marks when s reflects post-reset input.
  always_ff @(posedge clk) begin
    if (init) begin
      r_sync1_r1 <= '0;
      r_sync1_r0 <= '0;
      r_s_r1     <= '0;
      r_s_r0     <= '0;
      r_fill     <= 2'b00;
    end else begin
      r_sync1_r1 <= {c_rail1, d_rail1};
      r_sync1_r0 <= {c_rail0, d_rail0};
      r_s_r1     <= r_sync1_r1;
      r_s_r0     <= r_sync1_r0;
      r_fill     <= {r_fill[0], 1'b1};
    end
  end

  // Classify s and count how many consecutive samples it has held its value.
  always_comb begin
    w_same     = (r_s_r1 == r_prev_r1) && (r_s_r0 == r_prev_r0);
    w_run      = '0;
    if (!w_valid_s) begin
      w_run = '0;
    end else if (!w_same) begin
      w_run = ONE_C;
    end else if (r_run >= STABLE_C) begin
      w_run = STABLE_C;
    end else begin
      w_run = r_run + ONE_C;
    end
    w_stable   = w_valid_s && (w_run >= STABLE_C);
    w_acc_null = w_stable && pairs_null(r_s_r1, r_s_r0);
    w_acc_data = w_stable && pairs_complete(r_s_r1, r_s_r0);
    w_illegal  = w_valid_s && pairs_illegal(r_s_r1, r_s_r0);
  end

  // Remember the previous sample and the running stability count.
  always_ff @(posedge clk) begin
    if (init) begin
      r_prev_r1 <= '0;
      r_prev_r0 <= '0;
      r_run     <= '0;
    end else begin
      r_prev_r1 <= r_s_r1;
      r_prev_r0 <= r_s_r0;
      r_run     <= w_run;
    end
  end

  // Next state: NULL is only acknowledged once the output register is free.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_WAIT_NULL: begin
        if (w_acc_null && (!r_out_valid || out_ready)) begin
          w_state_next = S_WAIT_DATA;
        end else begin
          w_state_next = S_WAIT_NULL;
        end
      end
      S_WAIT_DATA: begin
        if (w_acc_data) begin
          w_capture    = 1'b1;
          w_state_next = S_WAIT_NULL;
        end else begin
          w_state_next = S_WAIT_DATA;
        end
      end
      default: begin
        w_state_next = S_WAIT_NULL;
      end
    endcase
  end

  // State register; ki requests DATA exactly while waiting for it.
  always_ff @(posedge clk) begin
    if (init) begin
      r_state <= S_WAIT_NULL;
      r_ki    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ki    <= (w_state_next == S_WAIT_DATA);
    end
  end

  // Sequence check: a captured word must be the previous word plus one.
  always_comb begin
    w_seq_bad = 1'b0;
    if (CHECK_SEQ && r_have_prev) begin
      w_seq_bad = (r_s_r1[W-1:0] != (r_seq_prev + INC_C)) ||
                  (r_s_r1[W] != (&r_seq_prev));
    end else begin
      w_seq_bad = 1'b0;
    end
  end

  // Output word register, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (init) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_carry   <= 1'b0;
      r_word_count  <= 32'd0;
      r_err_illegal <= 1'b0;
      r_seq_err     <= 1'b0;
      r_seq_prev    <= '0;
      r_have_prev   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_s_r1[W-1:0];
        r_out_carry  <= r_s_r1[W];
        r_word_count <= r_word_count + 32'd1;
        r_seq_prev   <= r_s_r1[W-1:0];
        r_have_prev  <= 1'b1;
        r_seq_err    <= r_seq_err | w_seq_bad;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_err_illegal <= r_err_illegal | w_illegal;
    end
  end

  assign ki          = r_ki;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_carry   = r_out_carry;
  assign word_count  = r_word_count;
  assign err_illegal = r_err_illegal;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_ncl_dualrail_sync_rx.sv
// Self-checking bench for ncl_dualrail_sync_rx (W=8, STABLE=2).
// Expected words go into a scoreboard queue when driven and are popped
// and compared when the receiver presents them.
module tb_ncl_dualrail_sync_rx;

  localparam int W = 8;

  logic         clk;
  logic         init;
  logic [W-1:0] d_rail1, d_rail0;
  logic         c_rail1, c_rail0;
  logic         ki;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_carry;
  logic [31:0]  word_count;
  logic         err_illegal;
  logic         seq_err;

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ncl_dualrail_sync_rx #(.W(W), .STABLE(2), .CHECK_SEQ(1'b1)) dut (
    .clk        (clk),
    .init       (init),
    .d_rail1    (d_rail1),
    .d_rail0    (d_rail0),
    .c_rail1    (c_rail1),
    .c_rail0    (c_rail0),
    .ki         (ki),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry),
    .word_count (word_count),
    .err_illegal(err_illegal),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_word(input logic [W-1:0] d, input logic c);
    d_rail1 = d;
    d_rail0 = ~d;
    c_rail1 = c;
    c_rail0 = ~c;
  endtask

  task automatic drive_null();
    d_rail1 = '0;
    d_rail0 = '0;
    c_rail1 = 1'b0;
    c_rail0 = 1'b0;
  endtask

  task automatic wait_ki(input logic val, input string name);
    for (int k = 0; k < 20; k++) begin
      if (ki === val) break;
      tick(1);
    end
    n_checks++;
    if (ki !== val) begin
      n_fail++;
      $display("FAIL %s got ki=%b required ki=%b", name, ki, val);
    end
  endtask

  task automatic reset_and_arm();
    init = 1'b1;
    drive_null();
    tick(2);
    init = 1'b0;
    sb.delete();
    wait_ki(1'b1, "arm_ki");
  endtask

  // Drive one word, wait for its capture, check it, then return NULL.
  task automatic feed_word(input logic [W-1:0] d, input logic c);
    exp_t e;
    drive_word(d, c);
    sb.push_back('{d: d, c: c});
    wait_ki(1'b0, "feed_ki_fall");
    n_checks++;
    if (sb.size() == 0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL feed_capture got valid=%b required valid=1", out_valid);
      sb.delete();
    end else begin
      e = sb.pop_front();
      if ({out_carry, out_data} !== {e.c, e.d}) begin
        n_fail++;
        $display("FAIL feed_data got %b_%h required %b_%h", out_carry, out_data, e.c, e.d);
      end
    end
    drive_null();
    wait_ki(1'b1, "feed_ki_rise");
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    init = 1'b1;
    drive_null();
    tick(2);
    n_checks++;
    if ({ki, out_valid, err_illegal, seq_err} !== 4'b0000 || word_count !== 32'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values got ki=%b v=%b ill=%b seq=%b cnt=%0d d=%h required all zero",
               ki, out_valid, err_illegal, seq_err, word_count, out_data);
    end
    init = 1'b0;
    tick(3);
    n_checks++;
    if (ki !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ki_early got ki=%b required ki=0 after 3 edges", ki);
    end
    tick(1);
    n_checks++;
    if (ki !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ki_rise got ki=%b v=%b required ki=1 v=0 after 4 edges", ki, out_valid);
    end
  endtask

  task automatic test_capture();
    exp_t e;
    out_ready = 1'b1;
    drive_word(8'h05, 1'b0);
    sb.push_back('{d: 8'h05, c: 1'b0});
    tick(3);
    n_checks++;
    if (out_valid !== 1'b0 || ki !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_early got v=%b ki=%b required v=0 ki=1", out_valid, ki);
    end
    tick(1);
    n_checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || {out_carry, out_data} !== {e.c, e.d} || ki !== 1'b0 || word_count !== 32'd1) begin
      n_fail++;
      $display("FAIL capture_word got v=%b d=%h c=%b ki=%b cnt=%0d required v=1 d=%h c=%b ki=0 cnt=1",
               out_valid, out_data, out_carry, ki, word_count, e.d, e.c);
    end
    drive_null();
    tick(3);
    n_checks++;
    if (ki !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_null_early got ki=%b v=%b required ki=0 v=0", ki, out_valid);
    end
    tick(1);
    n_checks++;
    if (ki !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_null_ki got ki=%b required ki=1", ki);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    reset_and_arm();
    out_ready = 1'b0;
    drive_word(8'h05, 1'b0);
    sb.push_back('{d: 8'h05, c: 1'b0});
    tick(4);
    n_checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || {out_carry, out_data} !== {e.c, e.d}) begin
      n_fail++;
      $display("FAIL bp_capture got v=%b d=%h required v=1 d=%h", out_valid, out_data, e.d);
    end
    drive_null();
    tick(6);
    n_checks++;
    if (ki !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h05) begin
      n_fail++;
      $display("FAIL bp_hold got ki=%b v=%b d=%h required ki=0 v=1 d=05", ki, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_checks++;
    if (ki !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got ki=%b v=%b required ki=1 v=0", ki, out_valid);
    end
  endtask

  task automatic test_sequence();
    reset_and_arm();
    out_ready = 1'b1;
    feed_word(8'hFE, 1'b0);
    feed_word(8'hFF, 1'b0);
    feed_word(8'h00, 1'b1);
    n_checks++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_good got seq_err=%b required 0", seq_err);
    end
    feed_word(8'h02, 1'b0);
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_skip got seq_err=%b required 1", seq_err);
    end
    feed_word(8'h03, 1'b0);
    n_checks++;
    if (seq_err !== 1'b1 || word_count !== 32'd5) begin
      n_fail++;
      $display("FAIL seq_sticky got seq_err=%b cnt=%0d required 1 cnt=5", seq_err, word_count);
    end
  endtask

  task automatic test_partial();
    exp_t e;
    reset_and_arm();
    out_ready = 1'b1;
    d_rail1 = 8'h10;
    d_rail0 = 8'hE7;
    c_rail1 = 1'b0;
    c_rail0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_checks++;
      if (out_valid !== 1'b0 || ki !== 1'b1) begin
        n_fail++;
        $display("FAIL partial_hold cycle=%0d got v=%b ki=%b required v=0 ki=1", i, out_valid, ki);
      end
    end
    d_rail0 = 8'hEF;
    sb.push_back('{d: 8'h10, c: 1'b0});
    tick(3);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_early got v=%b required v=0", out_valid);
    end
    tick(1);
    n_checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || {out_carry, out_data} !== {e.c, e.d} || ki !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_capture got v=%b d=%h ki=%b required v=1 d=%h ki=0",
               out_valid, out_data, ki, e.d);
    end
  endtask

  task automatic test_illegal_and_midreset();
    drive_null();
    wait_ki(1'b1, "ill_arm_ki");
    d_rail1 = 8'h01;
    d_rail0 = 8'hFF;
    c_rail1 = 1'b0;
    c_rail0 = 1'b1;
    tick(6);
    n_checks++;
    if (err_illegal !== 1'b1 || out_valid !== 1'b0 || ki !== 1'b1 || word_count !== 32'd1) begin
      n_fail++;
      $display("FAIL illegal got ill=%b v=%b ki=%b cnt=%0d required ill=1 v=0 ki=1 cnt=1",
               err_illegal, out_valid, ki, word_count);
    end
    drive_word(8'h20, 1'b0);
    tick(2);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    sb.delete();
    n_checks++;
    if ({ki, out_valid, err_illegal, seq_err, out_carry} !== 5'b00000 || word_count !== 32'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_values got ki=%b v=%b ill=%b seq=%b cnt=%0d d=%h required all zero",
               ki, out_valid, err_illegal, seq_err, word_count, out_data);
    end
    tick(8);
    n_checks++;
    if (ki !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_data_ignored got ki=%b v=%b required ki=0 v=0", ki, out_valid);
    end
    drive_null();
    tick(3);
    n_checks++;
    if (ki !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_null_early got ki=%b required ki=0", ki);
    end
    tick(1);
    n_checks++;
    if (ki !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_null_ki got ki=%b required ki=1", ki);
    end
  endtask

  initial begin
    init      = 1'b1;
    out_ready = 1'b1;
    drive_null();
    test_reset();
    test_capture();
    test_backpressure();
    test_sequence();
    test_partial();
    test_illegal_and_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
